// File: rtl/skinny_mask_pkg.sv
// Shared constants and helpers for the masked SKINNY-64 4-bit S-box datapaths.
package skinny_mask_pkg;

  localparam int SHARES = 3;
  localparam int NIB    = 4;
  localparam int RND    = 8;

  // AFF_C is the constant term of the inner quadratic; INV_AFF_C is the
  // inverse affine layer applied after the outer quadratic.
  localparam logic [NIB-1:0] AFF_C     = 4'h8;
  localparam logic [NIB-1:0] INV_AFF_C = 4'h1;

  localparam logic [NIB-1:0] SINV_TABLE [16] = '{
    4'h3, 4'h4, 4'h6, 4'h8, 4'hc, 4'ha, 4'h1, 4'he,
    4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hb, 4'hd, 4'hf
  };

  // Cross terms of one share domain for a shared AND: summed over the three
  // rotations this yields x*y while each call sees only two share indices.
  function automatic logic qterm(input logic xa, input logic ya,
                                 input logic xb, input logic yb);
    return (xa & ya) ^ (xa & yb) ^ (xb & ya);
  endfunction

endpackage

// File: rtl/skinny_inv_quad_share.sv
// One 3-share quadratic layer of the inverse SKINNY-64 S-box; OUTER selects the
// randomness-refreshed outer quadratic, otherwise the unrefreshed inner one.
module skinny_inv_quad_share
  import skinny_mask_pkg::*;
#(
  parameter bit OUTER = 1'b1
) (
  input  logic [NIB-1:0] s1,
  input  logic [NIB-1:0] s2,
  input  logic [NIB-1:0] s3,
  input  logic [RND-1:0] rnd,
  output logic [NIB-1:0] o1,
  output logic [NIB-1:0] o2,
  output logic [NIB-1:0] o3
);

  logic [RND-1:0] rnd_s;

  // Component function fed by shares a (linear part) and b; share i is never an input of component i.
  function automatic logic [NIB-1:0] comp(input logic [NIB-1:0] a, input logic [NIB-1:0] b);
    logic [NIB-1:0] z;
    if (OUTER) begin
      z[0] = a[0] ^ a[2] ^ a[3] ^ qterm(a[2], a[3], b[2], b[3]);
      z[1] = a[0] ^ a[1] ^ a[2] ^ qterm(a[0], a[3], b[0], b[3])
                                ^ qterm(a[2], a[3], b[2], b[3]);
      z[2] = a[2];
      z[3] = a[3];
    end else begin
      z[0] = a[3] ^ a[2] ^ a[0] ^ qterm(a[2], a[1], b[2], b[1])
                                ^ qterm(a[0], a[1], b[0], b[1]);
      z[1] = a[0];
      z[2] = a[1];
      z[3] = a[2] ^ a[0] ^ a[1] ^ qterm(a[0], a[1], b[0], b[1]);
    end
    return z;
  endfunction

  assign rnd_s = OUTER ? rnd : '0;

  // The two random nibbles cancel across the three output shares.
  assign o1 = comp(s2, s3) ^ rnd_s[3:0];
  assign o2 = comp(s3, s1) ^ rnd_s[7:4];
  assign o3 = comp(s1, s2) ^ rnd_s[3:0] ^ rnd_s[7:4];

endmodule

// File: rtl/skinny_inv_sbox_masked.sv
// Three-share masked inverse SKINNY-64 S-box in a 2-deep valid/ready pipeline.
// Define SKINNY_INV_SBOX_CLEAR_EN to load zero shares into stages that go empty.
module skinny_inv_sbox_masked
  import skinny_mask_pkg::INV_AFF_C;
  import skinny_mask_pkg::AFF_C;
#(
  parameter int SHARES = skinny_mask_pkg::SHARES,
  parameter int NIB    = skinny_mask_pkg::NIB,
  parameter int RND    = skinny_mask_pkg::RND
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NIB-1:0] in1,
  input  logic [NIB-1:0] in2,
  input  logic [NIB-1:0] in3,
  input  logic [RND-1:0] r,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [NIB-1:0] out1,
  output logic [NIB-1:0] out2,
  output logic [NIB-1:0] out3,
  output logic           out_valid,
  input  logic           out_ready
);

  if ((SHARES != skinny_mask_pkg::SHARES) || (NIB != skinny_mask_pkg::NIB) ||
      (RND != skinny_mask_pkg::RND)) begin : g_param_check
    $error("skinny_inv_sbox_masked: only SHARES=3, NIB=4, RND=8 are supported");
  end

  logic           adv_a, adv_b;
  logic           v_a_q, v_a_d, v_b_q, v_b_d;
  logic [NIB-1:0] a1_q, a2_q, a3_q, a1_d, a2_d, a3_d;
  logic [NIB-1:0] out1_q, out2_q, out3_q, out1_d, out2_d, out3_d;
  logic [NIB-1:0] qa1, qa2, qa3, qb1, qb2, qb3;

  skinny_inv_quad_share #(.OUTER(1'b1)) u_outer (
    .s1(in1), .s2(in2), .s3(in3), .rnd(r),
    .o1(qa1), .o2(qa2), .o3(qa3)
  );

  skinny_inv_quad_share #(.OUTER(1'b0)) u_inner (
    .s1(a1_q), .s2(a2_q), .s3(a3_q), .rnd('0),
    .o1(qb1), .o2(qb2), .o3(qb3)
  );

  // Handshake depends only on the valid bits and out_ready, never on share data.
  assign adv_b    = out_ready | ~v_b_q;
  assign adv_a    = adv_b | ~v_a_q;
  assign in_ready = adv_a;

  // Stage A next state: load on advance, otherwise hold every share untouched.
  always_comb begin
    v_a_d = v_a_q;
    a1_d  = a1_q;
    a2_d  = a2_q;
    a3_d  = a3_q;
    if (adv_a) begin
      v_a_d = in_valid;
`ifdef SKINNY_INV_SBOX_CLEAR_EN
      if (in_valid) begin
        a1_d = qa1 ^ INV_AFF_C;
        a2_d = qa2;
        a3_d = qa3;
      end else begin
        a1_d = '0;
        a2_d = '0;
        a3_d = '0;
      end
`else
      a1_d = qa1 ^ INV_AFF_C;
      a2_d = qa2;
      a3_d = qa3;
`endif
    end else begin
      v_a_d = v_a_q;
    end
  end

  // Stage B next state: inner quadratic of stage A, same hold rule.
  always_comb begin
    v_b_d  = v_b_q;
    out1_d = out1_q;
    out2_d = out2_q;
    out3_d = out3_q;
    if (adv_b) begin
      v_b_d = v_a_q;
`ifdef SKINNY_INV_SBOX_CLEAR_EN
      if (v_a_q) begin
        out1_d = qb1 ^ AFF_C;
        out2_d = qb2;
        out3_d = qb3;
      end else begin
        out1_d = '0;
        out2_d = '0;
        out3_d = '0;
      end
`else
      out1_d = qb1 ^ AFF_C;
      out2_d = qb2;
      out3_d = qb3;
`endif
    end else begin
      v_b_d = v_b_q;
    end
  end

  // Pipeline registers; reset drops any in-flight nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_a_q  <= 1'b0;
      v_b_q  <= 1'b0;
      a1_q   <= '0;
      a2_q   <= '0;
      a3_q   <= '0;
      out1_q <= '0;
      out2_q <= '0;
      out3_q <= '0;
    end else begin
      v_a_q  <= v_a_d;
      v_b_q  <= v_b_d;
      a1_q   <= a1_d;
      a2_q   <= a2_d;
      a3_q   <= a3_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
      out3_q <= out3_d;
    end
  end

  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out3      = out3_q;
  assign out_valid = v_b_q;

endmodule

// File: tb/tb_skinny_inv_sbox_masked.sv
// Directed self-checking bench for skinny_inv_sbox_masked (also covers the
// SKINNY_INV_SBOX_CLEAR_EN build when that macro is defined).
module tb_skinny_inv_sbox_masked;
  import skinny_mask_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] in1, in2, in3;
  logic [7:0] r;
  logic       in_valid, in_ready;
  logic [3:0] out1, out2, out3;
  logic       out_valid, out_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  skinny_inv_sbox_masked dut (
    .clk(clk), .rst_n(rst_n),
    .in1(in1), .in2(in2), .in3(in3), .r(r),
    .in_valid(in_valid), .in_ready(in_ready),
    .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] x);
    logic [3:0] s1, s2;
    s1       = 4'($urandom);
    s2       = 4'($urandom);
    in_valid = v;
    in1      = s1;
    in2      = s2;
    in3      = x ^ s1 ^ s2;
    r        = 8'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #3;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    tests_run++;
    if ({out1, out2, out3} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_shares: got %h want 000", {out1, out2, out3});
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sweep();
    logic [3:0] got;
    out_ready = 1'b1;
    for (int x = 0; x < 16; x++) begin
      drive(1'b1, 4'(x));
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL sweep_in_ready x=%h: got %b want 1", x, in_ready);
      end
      step();
      drive(1'b0, 4'h0);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL sweep_early x=%h: out_valid %b want 0 one cycle after accept", x, out_valid);
      end
      step();
      @(negedge clk);
      got = out1 ^ out2 ^ out3;
      tests_run++;
      if (out_valid !== 1'b1 || got !== SINV_TABLE[x]) begin
        tests_failed++;
        $display("FAIL sweep x=%h: valid=%b xor=%h want valid=1 xor=%h", x, out_valid, got, SINV_TABLE[x]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    logic [3:0]  got;
    held      = 12'h000;
    out_ready = 1'b1;
    drive(1'b1, 4'h1);
    step();
    drive(1'b1, 4'h2);
    step();
    drive(1'b0, 4'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = out1 ^ out2 ^ out3;
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_in_ready cyc=%0d: got %b want 0", i, in_ready);
      end
      tests_run++;
      if (out_valid !== 1'b1 || got !== 4'h4) begin
        tests_failed++;
        $display("FAIL stall_value cyc=%0d: valid=%b xor=%h want valid=1 xor=4", i, out_valid, got);
      end
      if (i == 0) begin
        held = {out1, out2, out3};
      end else begin
        tests_run++;
        if ({out1, out2, out3} !== held) begin
          tests_failed++;
          $display("FAIL stall_hold cyc=%0d: shares %h want %h", i, {out1, out2, out3}, held);
        end
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    got = out1 ^ out2 ^ out3;
    tests_run++;
    if (out_valid !== 1'b1 || got !== 4'h4 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_first: valid=%b xor=%h in_ready=%b want 1/4/1", out_valid, got, in_ready);
    end
    step();
    @(negedge clk);
    got = out1 ^ out2 ^ out3;
    tests_run++;
    if (out_valid !== 1'b1 || got !== 4'h6) begin
      tests_failed++;
      $display("FAIL release_second: valid=%b xor=%h want valid=1 xor=6", out_valid, got);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_drain: out_valid %b want 0", out_valid);
    end
    step();
  endtask

  task automatic test_streaming();
    logic [3:0] xs [16];
    logic [3:0] got;
    for (int i = 0; i < 16; i++) xs[i] = 4'((i * 7 + 3) % 16);
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(1'b1, xs[k]);
      else drive(1'b0, 4'h0);
      @(negedge clk);
      got = out1 ^ out2 ^ out3;
      if (k < 2) begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_fill k=%0d: out_valid %b want 0", k, out_valid);
        end
      end else begin
        tests_run++;
        if (out_valid !== 1'b1 || got !== SINV_TABLE[xs[k-2]]) begin
          tests_failed++;
          $display("FAIL stream k=%0d: valid=%b xor=%h want valid=1 xor=%h", k, out_valid, got, SINV_TABLE[xs[k-2]]);
        end
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_in_ready k=%0d: got %b want 1", k, in_ready);
      end
      step();
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_end: out_valid %b want 0", out_valid);
    end
    step();
  endtask

  task automatic test_async_reset();
    logic [3:0] got;
    out_ready = 1'b1;
    drive(1'b1, 4'h7);
    step();
    drive(1'b1, 4'h9);
    step();
    drive(1'b0, 4'h0);
    #2;
    got = out1 ^ out2 ^ out3;
    tests_run++;
    if (out_valid !== 1'b1 || got !== 4'he) begin
      tests_failed++;
      $display("FAIL arst_before: valid=%b xor=%h want valid=1 xor=e", out_valid, got);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_immediate: out_valid %b want 0", out_valid);
    end
    step();
    step();
    #3;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL arst_stale cyc=%0d: out_valid %b want 0", i, out_valid);
      end
      step();
    end
    drive(1'b1, 4'hb);
    step();
    drive(1'b0, 4'h0);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_next_early: out_valid %b want 0", out_valid);
    end
    step();
    @(negedge clk);
    got = out1 ^ out2 ^ out3;
    tests_run++;
    if (out_valid !== 1'b1 || got !== 4'h7) begin
      tests_failed++;
      $display("FAIL arst_next: valid=%b xor=%h want valid=1 xor=7", out_valid, got);
    end
    step();
  endtask

  task automatic test_share_independence();
    logic [3:0] got, f1, f2, f3;
    logic       var1, var2, var3;
    f1 = 4'h0; f2 = 4'h0; f3 = 4'h0;
    var1 = 1'b0; var2 = 1'b0; var3 = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 1002; k++) begin
      if (k < 1000) drive(1'b1, 4'h5);
      else drive(1'b0, 4'h0);
      @(negedge clk);
      if (k >= 2) begin
        got = out1 ^ out2 ^ out3;
        tests_run++;
        if (out_valid !== 1'b1 || got !== 4'ha) begin
          tests_failed++;
          $display("FAIL indep k=%0d: valid=%b xor=%h want valid=1 xor=a", k, out_valid, got);
        end
        if (k == 2) begin
          f1 = out1; f2 = out2; f3 = out3;
        end else begin
          if (out1 !== f1) var1 = 1'b1;
          if (out2 !== f2) var2 = 1'b1;
          if (out3 !== f3) var3 = 1'b1;
        end
      end
      step();
    end
    tests_run++;
    if (var1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL indep_out1_const: out1 stuck at %h, want varying", f1);
    end
    tests_run++;
    if (var2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL indep_out2_const: out2 stuck at %h, want varying", f2);
    end
    tests_run++;
    if (var3 !== 1'b1) begin
      tests_failed++;
      $display("FAIL indep_out3_const: out3 stuck at %h, want varying", f3);
    end
  endtask

`ifdef SKINNY_INV_SBOX_CLEAR_EN
  task automatic test_clear();
    logic [3:0] got;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8 && (k % 2) == 0) drive(1'b1, 4'(k + 3));
      else drive(1'b0, 4'h0);
      @(negedge clk);
      got = out1 ^ out2 ^ out3;
      if (k >= 2 && (k % 2) == 0) begin
        tests_run++;
        if (out_valid !== 1'b1 || got !== SINV_TABLE[k+1]) begin
          tests_failed++;
          $display("FAIL clear_value k=%0d: valid=%b xor=%h want valid=1 xor=%h", k, out_valid, got, SINV_TABLE[k+1]);
        end
      end else begin
        tests_run++;
        if (out_valid !== 1'b0 || {out1, out2, out3} !== 12'h000) begin
          tests_failed++;
          $display("FAIL clear_idle k=%0d: valid=%b shares=%h want valid=0 shares=000", k, out_valid, {out1, out2, out3});
        end
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_backpressure();
    test_streaming();
    test_async_reset();
    test_share_independence();
`ifdef SKINNY_INV_SBOX_CLEAR_EN
    test_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
